// File: rtl/grayscale_pkg.sv
// Shared constants and types for the grayscale stream controller.
// Luma coefficients are scaled by 1000 and stay in an 18-bit sum.
package grayscale_pkg;

    localparam int unsigned COEF_R    = 299;
    localparam int unsigned COEF_G    = 587;
    localparam int unsigned COEF_B    = 114;
    localparam int unsigned GRAY_DIV  = 1000;
    localparam int          PIX_SUM_W = 18;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/gray_pixel_calc.sv
// Combinational RGB to 8-bit luma conversion.
// Weighted sum fits 18 bits; the quotient never exceeds 255.
module gray_pixel_calc
    import grayscale_pkg::*;
(
    input  logic [23:0] rgb,
    output logic [7:0]  gray
);

    localparam logic [PIX_SUM_W-1:0] CR = PIX_SUM_W'(COEF_R);
    localparam logic [PIX_SUM_W-1:0] CG = PIX_SUM_W'(COEF_G);
    localparam logic [PIX_SUM_W-1:0] CB = PIX_SUM_W'(COEF_B);
    localparam logic [PIX_SUM_W-1:0] DV = PIX_SUM_W'(GRAY_DIV);

    logic [PIX_SUM_W-1:0] r_ext;
    logic [PIX_SUM_W-1:0] g_ext;
    logic [PIX_SUM_W-1:0] b_ext;
    logic [PIX_SUM_W-1:0] sum;

    assign r_ext = {{(PIX_SUM_W-8){1'b0}}, rgb[7:0]};
    assign g_ext = {{(PIX_SUM_W-8){1'b0}}, rgb[15:8]};
    assign b_ext = {{(PIX_SUM_W-8){1'b0}}, rgb[23:16]};

    assign sum  = CR * r_ext + CG * g_ext + CB * b_ext;
    assign gray = 8'(sum / DV);

endmodule

// File: rtl/grayscale_stream_ctrl.sv
// Frame sequencer: converts RGB pixels to luma and packs
// four luma bytes per output word with a last-word marker.
module grayscale_stream_ctrl
    import grayscale_pkg::*;
#(
    parameter int PIX_CNT_W = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PIX_CNT_W-1:0] pixel_count,
    output logic                 busy,
    output logic                 done,
    input  logic [31:0]          s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [31:0]          m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast
);

    state_t               state;
    state_t               state_nx;
    logic [PIX_CNT_W-1:0] remaining;
    logic [1:0]           lane_idx;
    logic [31:0]          pack;
    logic [31:0]          pack_merged;
    logic [7:0]           gray;
    logic                 accept;
    logic                 last_pix;
    logic                 word_load;
    logic                 out_hs;
    logic                 unused_hi;

    gray_pixel_calc u_calc (
        .rgb  (s_tdata[23:0]),
        .gray (gray)
    );

    // Top byte of the input word carries no pixel data.
    assign unused_hi = ^s_tdata[31:24];

    assign s_tready  = (state == RUN) && (remaining != '0)
                     && (!m_tvalid || m_tready);
    assign accept    = s_tvalid && s_tready;
    assign last_pix  = accept && (remaining == PIX_CNT_W'(1));
    assign word_load = accept && ((lane_idx == 2'd3) || last_pix);
    assign out_hs    = m_tvalid && m_tready;

    // Insert the current pixel's luma into its byte lane.
    always_comb begin
        pack_merged = pack;
        pack_merged[{lane_idx, 3'b000} +: 8] = gray;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (pixel_count != '0) state_nx = RUN;
                    else                   state_nx = DONE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_pix) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_hs && m_tlast) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Pixel counter, lane index and partial-word pack register.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
            lane_idx  <= '0;
            pack      <= '0;
        end else if ((state == IDLE) && start) begin
            remaining <= pixel_count;
            lane_idx  <= '0;
            pack      <= '0;
        end else if (accept) begin
            remaining <= remaining - PIX_CNT_W'(1);
            lane_idx  <= lane_idx + 2'd1;
            pack      <= word_load ? '0 : pack_merged;
        end
    end

    // Output word register; a new word takes priority over a drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (word_load) begin
            m_tdata  <= pack_merged;
            m_tvalid <= 1'b1;
            m_tlast  <= last_pix;
        end else if (out_hs) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end
    end

endmodule
